// File: rtl/adc_serial_sampler.sv
// Frame-paced sampler for an 18-bit SPI-style ADC: CONVST, conversion wait, MSB-first readout.
// Define ADC_OVERRANGE_EN to add the sticky o_ovr full-scale detector.
module adc_serial_sampler #(
    parameter int DATA_W      = 18,
    parameter int SCLK_DIV    = 2,
    parameter int CONV_CYCLES = 8,
    parameter int FRAME_LEN   = 128
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic                     i_miso,
    output logic                     o_convst,
    output logic                     o_cs_n,
    output logic                     o_sclk,
    output logic signed [DATA_W-1:0] o_data,
    output logic                     o_valid,
    output logic                     o_overrun,
    input  logic                     i_ovr_clr,
    output logic                     o_ovr
);

    localparam int SHIFT_LEN = 2 * SCLK_DIV * DATA_W;
    localparam int STEP_MAX  = (SHIFT_LEN > CONV_CYCLES) ? SHIFT_LEN : CONV_CYCLES;
    localparam int SW        = $clog2(STEP_MAX + 1);
    localparam int FW        = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

    state_t            state, state_nxt;
    logic [FW-1:0]     frame_cnt;
    logic [SW-1:0]     step, step_nxt;
    logic [SW-1:0]     phase;
    logic [DATA_W-1:0] sreg;
    logic              armed;
    logic              tick;
    logic              start;
    logic              conv_last;
    logic              shift_last;
    logic              sclk_rise;
    logic              last_edge;

    // armed masks the count-0 cycle right after reset release, so the first
    // conversion begins on the next full frame tick.
    assign tick       = (frame_cnt == '0);
    assign start      = armed && tick && i_en && (state == IDLE);
    assign conv_last  = (step == SW'(CONV_CYCLES - 1));
    assign shift_last = (step == SW'(SHIFT_LEN - 1));
    assign phase      = step % SW'(2 * SCLK_DIV);
    assign sclk_rise  = (state == SHIFT) && (phase == SW'(SCLK_DIV - 1));
    assign last_edge  = (state == SHIFT) && shift_last;

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        o_convst  = 1'b0;
        o_cs_n    = 1'b1;
        o_sclk    = 1'b0;
        o_overrun = tick && (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    o_convst  = 1'b1;
                    state_nxt = CONV;
                    step_nxt  = '0;
                end
            end
            CONV: begin
                if (conv_last) begin
                    state_nxt = SHIFT;
                    step_nxt  = '0;
                end else begin
                    step_nxt = step + SW'(1);
                end
            end
            SHIFT: begin
                // Low half-period first; the final high half doubles as the hold.
                o_cs_n = 1'b0;
                o_sclk = (phase >= SW'(SCLK_DIV));
                if (shift_last) begin
                    state_nxt = DONE;
                    step_nxt  = '0;
                end else begin
                    step_nxt = step + SW'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                step_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_cnt <= '0;
            armed     <= 1'b0;
            state     <= IDLE;
            step      <= '0;
            sreg      <= '0;
            o_data    <= '0;
            o_valid   <= 1'b0;
        end else begin
            frame_cnt <= (frame_cnt == FW'(FRAME_LEN - 1)) ? '0 : frame_cnt + FW'(1);
            armed     <= 1'b1;
            state     <= state_nxt;
            step      <= step_nxt;
            if (sclk_rise) begin
                sreg <= {sreg[DATA_W-2:0], i_miso};
            end
            // o_data and o_valid both change on the edge entering DONE.
            o_valid <= last_edge;
            if (last_edge) begin
                o_data <= sreg;
            end
        end
    end

`ifdef ADC_OVERRANGE_EN
    localparam logic [DATA_W-1:0] POS_FS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] NEG_FS = {1'b1, {(DATA_W-1){1'b0}}};

    // A full-scale capture outranks a clear arriving on the same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ovr <= 1'b0;
        end else if (last_edge && ((sreg == POS_FS) || (sreg == NEG_FS))) begin
            o_ovr <= 1'b1;
        end else if (i_ovr_clr) begin
            o_ovr <= 1'b0;
        end
    end
`else
    logic unused_ovr_clr;
    assign unused_ovr_clr = i_ovr_clr;
    assign o_ovr          = 1'b0;
`endif

endmodule

// File: tb/tb_adc_serial_sampler.sv
// Bench for adc_serial_sampler: a 128-cycle frame lane and a 60-cycle (overrunning) frame lane,
// each with an ADC model and a frame-timeline reference model.
module tb_adc_serial_sampler;

    localparam int W      = 18;
    localparam int DIV    = 2;
    localparam int CONV   = 8;
    localparam int DONE_T = 1 + CONV + 2 * DIV * W;
`ifdef ADC_OVERRANGE_EN
    localparam bit OVR_ON = 1'b1;
`else
    localparam bit OVR_ON = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b1;
    logic clr   = 1'b0;

    logic                conv  [2];
    logic                cs_n  [2];
    logic                sclk  [2];
    logic                valid [2];
    logic                ovrun [2];
    logic                ovr   [2];
    logic signed [W-1:0] data  [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    function automatic logic [W-1:0] word_of(input int k);
        case (k % 16)
            0:       return 18'h0ABCD;
            1:       return 18'h3FFFE;
            2:       return 18'h00001;
            3:       return 18'h1FFFF;
            4:       return 18'h0ABCD;
            5:       return 18'h1FFFF;
            6:       return 18'h20000;
            7:       return 18'h2AAAA;
            8:       return 18'h15A5A;
            9:       return 18'h00000;
            10:      return 18'h3C3C3;
            11:      return 18'h12345;
            12:      return 18'h1FFFF;
            13:      return 18'h00F0F;
            14:      return 18'h20001;
            default: return 18'h3FFFF;
        endcase
    endfunction

    function automatic bit orange(input logic [W-1:0] w);
        return (w == 18'h1FFFF) || (w == 18'h20000);
    endfunction

    task automatic chk(input string nm, input int ln, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s lane%0d cyc=%0d got=%h want=%h", nm, ln, cyc, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int FL = (g == 0) ? 128 : 60;
        logic miso_l = 1'b0;

        adc_serial_sampler #(
            .DATA_W(W), .SCLK_DIV(DIV), .CONV_CYCLES(CONV), .FRAME_LEN(FL)
        ) dut (
            .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_miso(miso_l),
            .o_convst(conv[g]), .o_cs_n(cs_n[g]), .o_sclk(sclk[g]),
            .o_data(data[g]), .o_valid(valid[g]), .o_overrun(ovrun[g]),
            .i_ovr_clr(clr), .o_ovr(ovr[g])
        );

        // ADC: picks a new word when chip select falls, shifts the next bit after each SCLK rise.
        int         n = 0;
        int         idx = 0;
        logic [W-1:0] word = '0;
        logic       prev_sclk = 1'b0;
        logic       prev_cs = 1'b1;
        initial forever begin
            @(negedge clk);
            if (cs_n[g]) begin
                idx = 0;
            end else begin
                if (prev_cs) begin
                    word = word_of(n);
                    n++;
                end
                if (sclk[g] && !prev_sclk) idx++;
            end
            miso_l    = (!cs_n[g] && idx < W) ? word[W-1-idx] : 1'b0;
            prev_sclk = sclk[g];
            prev_cs   = cs_n[g];
        end

        // Reference timeline: t counts cycles since the CONVST tick.
        int         cnt = 0;
        int         t = -1;
        int         k = 0;
        bit         armed = 1'b0;
        bit         clr_prev = 1'b0;
        bit         movr = 1'b0;
        bit         tick, busy, start, win, esclk;
        logic [W-1:0] cur = '0;
        logic [W-1:0] d = '0;
        initial forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_convst", g, 32'(conv[g]), 32'(0));
                chk("rst_cs_n", g, 32'(cs_n[g]), 32'(1));
                chk("rst_sclk", g, 32'(sclk[g]), 32'(0));
                chk("rst_valid", g, 32'(valid[g]), 32'(0));
                chk("rst_overrun", g, 32'(ovrun[g]), 32'(0));
                chk("rst_data", g, {14'b0, data[g]}, 32'(0));
                chk("rst_ovr", g, 32'(ovr[g]), 32'(0));
                cnt = 0; t = -1; armed = 1'b0; clr_prev = 1'b0; d = '0; movr = 1'b0;
            end else begin
                tick  = (cnt == 0);
                busy  = (t >= 1);
                start = tick && armed && (t < 0) && en;
                win   = (t >= CONV + 1) && (t <= CONV + 2 * DIV * W);
                esclk = win && ((((t - CONV - 1) / DIV) % 2) == 1);
                if (t == CONV + 1) begin
                    cur = word_of(k);
                    k++;
                end
                if (t == DONE_T) d = cur;
                if (OVR_ON) begin
                    if (t == DONE_T && orange(cur)) movr = 1'b1;
                    else if (clr_prev) movr = 1'b0;
                end
                chk("convst", g, 32'(conv[g]), 32'(start));
                chk("cs_n", g, 32'(cs_n[g]), 32'(!win));
                chk("sclk", g, 32'(sclk[g]), 32'(esclk));
                chk("valid", g, 32'(valid[g]), 32'(t == DONE_T));
                chk("overrun", g, 32'(ovrun[g]), 32'(tick && busy));
                chk("data", g, {14'b0, data[g]}, {14'b0, d});
                chk("ovr", g, 32'(ovr[g]), 32'(movr));
                clr_prev = clr;
                if (start) t = 1;
                else if (t >= DONE_T) t = -1;
                else if (t >= 1) t++;
                cnt   = (cnt == FL - 1) ? 0 : cnt + 1;
                armed = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) step();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc   = 0;

        go_to(120);
        chk("lit_overrun_tick", 1, 32'(ovrun[1]), 32'(1));
        go_to(128);
        chk("lit_first_convst", 0, 32'(conv[0]), 32'(1));
        go_to(141);
        chk("lit_valid", 1, 32'(valid[1]), 32'(1));
        chk("lit_data_after_overrun", 1, {14'b0, data[1]}, 32'h0ABCD);
        go_to(209);
        chk("lit_valid_cnt81", 0, 32'(valid[0]), 32'(1));
        chk("lit_data_0abcd", 0, {14'b0, data[0]}, 32'h0ABCD);
        go_to(337);
        chk("lit_data_neg2", 0, {14'b0, data[0]}, 32'h3FFFE);
        go_to(400);
        chk("lit_data_held", 0, {14'b0, data[0]}, 32'h3FFFE);
        go_to(465);
        chk("lit_data_pos1", 0, {14'b0, data[0]}, 32'h00001);
        go_to(593);
        chk("lit_ovr_set", 0, 32'(ovr[0]), 32'(OVR_ON));

        go_to(720);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("lit_ovr_cleared", 0, 32'(ovr[0]), 32'(0));

        go_to(848);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("lit_ovr_set_wins", 0, 32'(ovr[0]), 32'(OVR_ON));

        go_to(880);
        en = 1'b0;
        go_to(900);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("lit_ovr_clear2", 0, 32'(ovr[0]), 32'(0));
        go_to(1024);
        chk("lit_no_convst_en0", 0, 32'(conv[0]), 32'(0));
        chk("lit_data_unchanged", 0, {14'b0, data[0]}, 32'h1FFFF);
        go_to(1030);
        en = 1'b1;
        go_to(1152);
        chk("lit_convst_reenabled", 0, 32'(conv[0]), 32'(1));
        go_to(1233);
        chk("lit_data_negfs", 0, {14'b0, data[0]}, 32'h20000);

        go_to(1325);
        chk("lit_cs_mid_shift", 0, 32'(cs_n[0]), 32'(0));
        rst_n = 1'b0;
        #1;
        chk("lit_async_cs_n", 0, 32'(cs_n[0]), 32'(1));
        chk("lit_async_sclk", 0, 32'(sclk[0]), 32'(0));
        chk("lit_async_data", 0, {14'b0, data[0]}, 32'(0));
        chk("lit_async_ovr", 0, 32'(ovr[0]), 32'(0));
        repeat (3) step();
        rst_n = 1'b1;
        cyc   = 0;

        go_to(1);
        chk("lit_no_convst_after_release", 0, 32'(conv[0]), 32'(0));
        go_to(128);
        chk("lit_convst_after_reset", 0, 32'(conv[0]), 32'(1));
        go_to(209);
        chk("lit_valid_after_reset", 0, 32'(valid[0]), 32'(1));
        chk("lit_data_after_reset", 0, {14'b0, data[0]}, 32'h15A5A);
        go_to(420);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
